pipe_ctrl_hazard: RTL

Pipelined control and hazard unit for the five-stage MIPS core. It decodes the ID-stage opcode into a control bundle and carries that bundle through the ID/EX, EX/MEM and MEM/WB control registers. It detects load-use, taken-branch and multi-cycle-multiply hazards and drives the stall, flush and forwarding-select signals. It replaces the combinational-only decoder and owns all pipeline control state.

---
 rtl/ctrl_pkg.sv | 56 +++++
 rtl/pipe_ctrl_hazard_if.sv | 40 ++++
 rtl/ctrl_decoder.sv | 49 ++++
 rtl/pipe_ctrl_hazard.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the pipelined control / hazard unit:
// opcodes, ALU classes, forwarding selects and the per-stage control bundles.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_MUL   = 6'b011100;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10,
    ALU_MUL   = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic    reg_dst;
    logic    alu_src;
    alu_op_e alu_op;
    logic    branch;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    reg_write;
    logic    is_mul;
  } ctrl_t;

  // Later stages only carry the fields they still consume.
  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic reg_write;
  } mem_ctrl_t;

  typedef struct packed {
    logic mem_to_reg;
    logic reg_write;
  } wb_ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  function automatic logic uses_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_MUL);
  endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_if.sv
// ID-stage inputs and per-stage control / hazard outputs of pipe_ctrl_hazard.
interface pipe_ctrl_hazard_if #(
  parameter int unsigned REG_ADDR_W = 5
);
  logic [5:0]            opcode_id;
  logic [REG_ADDR_W-1:0] rs_id;
  logic [REG_ADDR_W-1:0] rt_id;
  logic [REG_ADDR_W-1:0] rd_id;
  logic                  branch_taken_ex;

  logic                  stall;
  logic                  flush_ifid;
  logic                  ex_reg_dst;
  logic                  ex_alu_src;
  logic                  ex_branch;
  logic [1:0]            ex_alu_op;
  logic                  mem_read;
  logic                  mem_write;
  logic                  wb_reg_write;
  logic                  wb_mem_to_reg;
  logic [REG_ADDR_W-1:0] ex_dst;
  logic [REG_ADDR_W-1:0] mem_dst;
  logic [REG_ADDR_W-1:0] wb_dst;
  logic [1:0]            fwd_a;
  logic [1:0]            fwd_b;

  modport master (
    output opcode_id, rs_id, rt_id, rd_id, branch_taken_ex,
    input  stall, flush_ifid, ex_reg_dst, ex_alu_src, ex_branch, ex_alu_op,
           mem_read, mem_write, wb_reg_write, wb_mem_to_reg,
           ex_dst, mem_dst, wb_dst, fwd_a, fwd_b
  );

  modport slave (
    input  opcode_id, rs_id, rt_id, rd_id, branch_taken_ex,
    output stall, flush_ifid, ex_reg_dst, ex_alu_src, ex_branch, ex_alu_op,
           mem_read, mem_write, wb_reg_write, wb_mem_to_reg,
           ex_dst, mem_dst, wb_dst, fwd_a, fwd_b
  );
endinterface

// File: rtl/ctrl_decoder.sv
// Combinational ID-stage decoder: opcode to control bundle; unknown opcodes
// decode to an all-zero bubble.
module ctrl_decoder
  import ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = CTRL_BUBBLE;
    case (opcode)
      OP_RTYPE: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_FUNCT;
      end
      OP_LW: begin
        ctrl.alu_src    = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.alu_op     = ALU_ADD;
      end
      OP_SW: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.alu_op    = ALU_ADD;
      end
      OP_BEQ: begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALU_SUB;
      end
      OP_ADDI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_ADD;
      end
      OP_MUL: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.is_mul    = 1'b1;
        ctrl.alu_op    = ALU_MUL;
      end
      default: ctrl = CTRL_BUBBLE;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl_hazard.sv
// Pipelined control for the five-stage core: ID decode, ID/EX..MEM/WB control
// registers, load-use / taken-branch / multi-cycle-mul hazards and forwarding.
module pipe_ctrl_hazard
  import ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned MUL_LATENCY = 3
) (
  input logic              clk,
  input logic              rst_n,
  pipe_ctrl_hazard_if.slave bus
);

  localparam int unsigned CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LATENCY - 1);

  ctrl_t                 id_ctrl_raw, id_ctrl;
  logic [REG_ADDR_W-1:0] id_dst;

  ctrl_t                 ex_ctrl_q, ex_ctrl_d;
  logic [REG_ADDR_W-1:0] ex_dst_q, ex_dst_d;
  logic [REG_ADDR_W-1:0] ex_rs_q, ex_rs_d;
  logic [REG_ADDR_W-1:0] ex_rt_q, ex_rt_d;
  mem_ctrl_t             mem_ctrl_q, mem_ctrl_d;
  logic [REG_ADDR_W-1:0] mem_dst_q, mem_dst_d;
  wb_ctrl_t              wb_ctrl_q, wb_ctrl_d;
  logic [REG_ADDR_W-1:0] wb_dst_q, wb_dst_d;
  logic [CNT_W-1:0]      mul_cnt_q, mul_cnt_d;

  logic     mul_busy, flush, load_use;
  fwd_sel_e fwd_a, fwd_b;

  ctrl_decoder u_dec (
    .opcode (bus.opcode_id),
    .ctrl   (id_ctrl_raw)
  );

  // Writes to $zero are dropped at decode so no later stage has to re-check.
  always_comb begin
    id_ctrl = id_ctrl_raw;
    id_dst  = id_ctrl_raw.reg_dst ? bus.rd_id : bus.rt_id;
    if (id_dst == '0) id_ctrl.reg_write = 1'b0;
  end

  always_comb begin
    mul_busy = ex_ctrl_q.is_mul && (mul_cnt_q != '0);
    flush    = ex_ctrl_q.branch && bus.branch_taken_ex;
    load_use = ex_ctrl_q.mem_read && (ex_dst_q != '0) &&
               ((ex_dst_q == bus.rs_id) ||
                ((ex_dst_q == bus.rt_id) && uses_rt(bus.opcode_id)));
  end

  always_comb begin
    ex_ctrl_d = id_ctrl;
    ex_dst_d  = id_dst;
    ex_rs_d   = bus.rs_id;
    ex_rt_d   = bus.rt_id;

    mem_ctrl_d.mem_read   = ex_ctrl_q.mem_read;
    mem_ctrl_d.mem_write  = ex_ctrl_q.mem_write;
    mem_ctrl_d.mem_to_reg = ex_ctrl_q.mem_to_reg;
    mem_ctrl_d.reg_write  = ex_ctrl_q.reg_write;
    mem_dst_d             = ex_dst_q;

    wb_ctrl_d.mem_to_reg = mem_ctrl_q.mem_to_reg;
    wb_ctrl_d.reg_write  = mem_ctrl_q.reg_write;
    wb_dst_d             = mem_dst_q;

    mul_cnt_d = '0;

    // A busy mul freezes ID/EX in place and feeds bubbles into EX/MEM.
    if (mul_busy) begin
      ex_ctrl_d  = ex_ctrl_q;
      ex_dst_d   = ex_dst_q;
      ex_rs_d    = ex_rs_q;
      ex_rt_d    = ex_rt_q;
      mem_ctrl_d = '0;
      mem_dst_d  = '0;
      mul_cnt_d  = mul_cnt_q - CNT_W'(1);
    end else if (flush || load_use) begin
      ex_ctrl_d = CTRL_BUBBLE;
      ex_dst_d  = '0;
      ex_rs_d   = '0;
      ex_rt_d   = '0;
    end else if (id_ctrl.is_mul) begin
      mul_cnt_d = MUL_LOAD;
    end
  end

  function automatic fwd_sel_e fwd_sel(
    input logic [REG_ADDR_W-1:0] src,
    input logic                  m_wr,
    input logic [REG_ADDR_W-1:0] m_dst,
    input logic                  w_wr,
    input logic [REG_ADDR_W-1:0] w_dst
  );
    if (m_wr && (m_dst != '0) && (m_dst == src)) return FWD_MEM;
    if (w_wr && (w_dst != '0) && (w_dst == src)) return FWD_WB;
    return FWD_RF;
  endfunction

  always_comb begin
    fwd_a = fwd_sel(ex_rs_q, mem_ctrl_q.reg_write, mem_dst_q, wb_ctrl_q.reg_write, wb_dst_q);
    fwd_b = fwd_sel(ex_rt_q, mem_ctrl_q.reg_write, mem_dst_q, wb_ctrl_q.reg_write, wb_dst_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ctrl_q  <= CTRL_BUBBLE;
      ex_dst_q   <= '0;
      ex_rs_q    <= '0;
      ex_rt_q    <= '0;
      mem_ctrl_q <= '0;
      mem_dst_q  <= '0;
      wb_ctrl_q  <= '0;
      wb_dst_q   <= '0;
      mul_cnt_q  <= '0;
    end else begin
      ex_ctrl_q  <= ex_ctrl_d;
      ex_dst_q   <= ex_dst_d;
      ex_rs_q    <= ex_rs_d;
      ex_rt_q    <= ex_rt_d;
      mem_ctrl_q <= mem_ctrl_d;
      mem_dst_q  <= mem_dst_d;
      wb_ctrl_q  <= wb_ctrl_d;
      wb_dst_q   <= wb_dst_d;
      mul_cnt_q  <= mul_cnt_d;
    end
  end

  assign bus.stall         = mul_busy || (load_use && !flush);
  assign bus.flush_ifid    = flush;
  assign bus.ex_reg_dst    = ex_ctrl_q.reg_dst;
  assign bus.ex_alu_src    = ex_ctrl_q.alu_src;
  assign bus.ex_branch     = ex_ctrl_q.branch;
  assign bus.ex_alu_op     = ex_ctrl_q.alu_op;
  assign bus.mem_read      = mem_ctrl_q.mem_read;
  assign bus.mem_write     = mem_ctrl_q.mem_write;
  assign bus.wb_reg_write  = wb_ctrl_q.reg_write;
  assign bus.wb_mem_to_reg = wb_ctrl_q.mem_to_reg;
  assign bus.ex_dst        = ex_dst_q;
  assign bus.mem_dst       = mem_dst_q;
  assign bus.wb_dst        = wb_dst_q;
  assign bus.fwd_a         = fwd_a;
  assign bus.fwd_b         = fwd_b;

endmodule
